vga_timing: RTL and testbench

Parametrised raster timing generator for VGA-class video: produces hsync, vsync, blanking, data-enable and pixel coordinates from a single system clock, with an internal pixel-clock-enable divider. It supersedes the fixed 640x480 hsync/vsync pair. Counts are exact (no off-by-one on line/frame length), and horizontal and vertical state share one clock domain. It sits between the board clock and the image generator, which consumes `o_x`, `o_y` and `o_de`.

---
 rtl/vga_timing.sv | 144 ++++++++++++++
 tb/tb_vga_timing.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: parametrised raster timing generator with an internal pixel-clock-enable divider.
// Every output is a flop; region decodes are registered from the next-count value.
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int FW       = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_pix_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [FW-1:0] o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DCW-1:0] DC_LAST  = DCW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0]  HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]  HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]  V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0]  VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]  VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DCW-1:0] dc_q, dc_d;
  logic           pend_q, pend_d;
  logic           pix_en_q, pix_en_d;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d;
  logic           hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic           tick;

  // A strobe leaves a pending advance that is consumed on the next enabled edge,
  // so a stall landing on a strobe cycle neither loses nor duplicates a pixel.
  always_comb begin
    tick          = (dc_q == DC_LAST);
    dc_d          = dc_q;
    pend_d        = pend_q;
    pix_en_d      = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    frame_d       = frame_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (i_en) begin
      dc_d     = tick ? '0 : dc_q + 1'b1;
      pend_d   = tick;
      pix_en_d = tick;
      if (pend_q) begin
        if (x_q == H_LAST) begin
          x_d          = '0;
          line_start_d = 1'b1;
          if (y_q == V_LAST) begin
            y_d           = '0;
            frame_start_d = 1'b1;
            frame_d       = frame_q + 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hblank_d = (x_d >= H_ACT_C);
    vblank_d = (y_d >= V_ACT_C);
    de_d     = ~hblank_d & ~vblank_d;
    hsync_d  = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d  = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dc_q          <= '0;
      pend_q        <= 1'b0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      dc_q          <= dc_d;
      pend_q        <= pend_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_q       <= frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_pix_en      = pix_en_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_de          = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a small raster (7x6 totals, CLK_DIV=2, mixed sync polarity).
// A position model driven by the count of enabled clock edges is checked after every edge.
module tb_vga_timing;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 4;
  localparam int H_FP     = 1;
  localparam int H_SYNC   = 1;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 3;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int HS_POL   = 0;
  localparam int VS_POL   = 1;
  localparam int CW       = 4;
  localparam int FW       = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          pixEn, hsync, vsync, hblank, vblank, de, lineStart, frameStart;
  logic [CW-1:0] x, y;
  logic [FW-1:0] frame;

  int errors     = 0;
  int checks     = 0;
  int enEdges    = 0;
  int cycleCount = 0;
  bit lastEn     = 1'b0;

  always #5 clk = ~clk;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(CW), .FW(FW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_pix_en(pixEn), .o_hsync(hsync), .o_vsync(vsync),
    .o_hblank(hblank), .o_vblank(vblank), .o_de(de),
    .o_x(x), .o_y(y),
    .o_line_start(lineStart), .o_frame_start(frameStart), .o_frame(frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pixel index is a pure function of enabled edges: strobes appear on every
  // CLK_DIV-th enabled edge and the position advances on the following one.
  task automatic checkOutput();
    int  p, pPrev, ex, ey;
    bit  expPix, expLs, inHs, inVs;
    p      = (enEdges == 0) ? 0 : (enEdges - 1) / CLK_DIV;
    pPrev  = (enEdges <= 1) ? 0 : (enEdges - 2) / CLK_DIV;
    ex     = p % H_TOTAL;
    ey     = (p / H_TOTAL) % V_TOTAL;
    expPix = lastEn && (enEdges > 0) && (enEdges % CLK_DIV == 0);
    expLs  = lastEn && (p != pPrev) && (ex == 0);
    inHs   = (ex >= H_ACTIVE + H_FP) && (ex < H_ACTIVE + H_FP + H_SYNC);
    inVs   = (ey >= V_ACTIVE + V_FP) && (ey < V_ACTIVE + V_FP + V_SYNC);
    chk("x", 32'(x), ex);
    chk("y", 32'(y), ey);
    chk("frame", 32'(frame), (p / (H_TOTAL * V_TOTAL)) % (1 << FW));
    chk("pix_en", 32'(pixEn), 32'(expPix));
    chk("line_start", 32'(lineStart), 32'(expLs));
    chk("frame_start", 32'(frameStart), 32'(expLs && ey == 0));
    chk("hblank", 32'(hblank), 32'(ex >= H_ACTIVE));
    chk("vblank", 32'(vblank), 32'(ey >= V_ACTIVE));
    chk("de_vs_xy", 32'(de), 32'(!((x >= CW'(H_ACTIVE)) || (y >= CW'(V_ACTIVE)))));
    chk("hsync", 32'(hsync), inHs ? HS_POL : 32'(HS_POL == 0));
    chk("vsync", 32'(vsync), inVs ? VS_POL : 32'(VS_POL == 0));
    if (frameStart === 1'b1) chk("fs_implies_ls", 32'(lineStart), 1);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cycleCount++;
      if (rst) begin
        enEdges = 0;
        lastEn  = 1'b0;
      end else begin
        lastEn = en;
        if (en) enEdges++;
      end
      #1 checkOutput();
    end
  endtask

  initial begin
    int n, relCycle, hsLow, vsHigh, deStrobes, rem, xHeld;

    $display("[TB] reset held");
    rst = 1'b1;
    en  = 1'b1;
    applyStimulus(3);
    chk("reset_x", 32'(x), 0);
    chk("reset_hsync", 32'(hsync), 1);
    chk("reset_vsync", 32'(vsync), 0);
    chk("reset_de", 32'(de), 1);

    rst = 1'b0;
    relCycle = cycleCount;
    applyStimulus(1);
    chk("first_strobe_e1", 32'(pixEn), 0);
    applyStimulus(1);
    chk("first_strobe_e2", 32'(pixEn), 1);
    chk("first_strobe_x", 32'(x), 0);
    applyStimulus(1);
    chk("x_after_strobe", 32'(x), 1);

    n = 0;
    while (frameStart !== 1'b1 && n < 200) begin
      applyStimulus(1);
      n++;
    end
    chk("first_frame_start_cycle", 32'(cycleCount - relCycle), 85);
    chk("first_frame_value", 32'(frame), 1);

    $display("[TB] measuring one full frame");
    n = 0; hsLow = 0; vsHigh = 0; deStrobes = 0;
    do begin
      applyStimulus(1);
      n++;
      if (hsync === 1'b0) hsLow++;
      if (vsync === 1'b1) vsHigh++;
      if (pixEn === 1'b1 && de === 1'b1) deStrobes++;
    end while (frameStart !== 1'b1 && n < 200);
    chk("frame_period", n, H_TOTAL * V_TOTAL * CLK_DIV);
    chk("hsync_cycles_per_frame", hsLow, H_SYNC * CLK_DIV * V_TOTAL);
    chk("vsync_cycles_per_frame", vsHigh, V_SYNC * H_TOTAL * CLK_DIV);
    chk("de_strobes_per_frame", deStrobes, H_ACTIVE * V_ACTIVE);
    chk("second_frame_value", 32'(frame), 2);

    $display("[TB] stall of 37 cycles mid-hsync");
    n = 0;
    while (!(hsync === 1'b0 && pixEn === 1'b0) && n < 50) begin
      applyStimulus(1);
      n++;
    end
    chk("hsync_found", 32'(hsync), 0);
    en = 1'b0;
    applyStimulus(37);
    chk("stall_x", 32'(x), H_ACTIVE + H_FP);
    chk("stall_hsync", 32'(hsync), 0);
    en = 1'b1;
    n = 0; rem = 0;
    do begin
      applyStimulus(1);
      n++;
      if (hsync === 1'b0) rem++;
    end while (hsync !== 1'b1 && n < 20);
    chk("hsync_remaining", rem, H_SYNC * CLK_DIV - 1);

    $display("[TB] stall landing on a strobe cycle");
    n = 0;
    while (pixEn !== 1'b1 && n < 10) begin
      applyStimulus(1);
      n++;
    end
    xHeld = int'(x);
    en = 1'b0;
    applyStimulus(5);
    chk("strobe_stall_x", 32'(x), xHeld);
    en = 1'b1;
    applyStimulus(1);
    chk("strobe_resume_x", 32'(x), (xHeld + 1) % H_TOTAL);

    $display("[TB] frame counter wrap");
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        applyStimulus(1);
        n++;
      end while (frameStart !== 1'b1 && n < 200);
      chk("frame_seq", 32'(frame), (3 + k) % (1 << FW));
    end

    $display("[TB] async reset mid-vsync");
    n = 0;
    while (!(vsync === 1'b1 && x == CW'(2)) && n < 200) begin
      applyStimulus(1);
      n++;
    end
    chk("vsync_found", 32'(vsync), 1);
    #2 rst = 1'b1;
    #1;
    enEdges = 0;
    lastEn  = 1'b0;
    chk("async_x", 32'(x), 0);
    chk("async_y", 32'(y), 0);
    chk("async_vsync", 32'(vsync), 0);
    chk("async_vblank", 32'(vblank), 0);
    checkOutput();
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(1);
    chk("rel_strobe_e1", 32'(pixEn), 0);
    applyStimulus(1);
    chk("rel_strobe_e2", 32'(pixEn), 1);
    applyStimulus(1);
    chk("rel_x", 32'(x), 1);
    applyStimulus(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
